intack_seq: RTL and testbench
=============================

INTACK_SEQ -- requirements
Module: intack_seq

Interface
REQ-001 SHALL have parameter INTA_W, default 2, cycles inta_n is held low per acknowledge pulse (legal 1..15).
REQ-002 SHALL have parameter GAP_W, default 1, cycles inta_n is held high between the two pulses (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port intr  input  1  interrupt request from the priority resolver.
REQ-006 SHALL have port if_en  input  1  CPU interrupt-enable flag; 0 blocks new acknowledge sequences.
REQ-007 SHALL have port data_in  input  8  vector byte driven by the interrupt controller during the second pulse.
REQ-008 SHALL have port inta_n  output  1  active-low interrupt acknowledge strobe to the controller.
REQ-009 SHALL have port vec  output  8  captured vector byte.
REQ-010 SHALL have port vec_valid  output  1  vec holds an unconsumed vector.
REQ-011 SHALL have port vec_ready  input  1  CPU core accepts vec when vec_ready and vec_valid are both 1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port spurious  output  1  vector flagged spurious (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, ACK1, GAP, ACK2, HOLD with one down-counter of width 4.
REQ-015 IDLE: intr=1 and if_en=1 sampled at an edge SHALL enter ACK1 at that edge; otherwise stay IDLE.
REQ-016 inta_n SHALL be a registered output, 0 exactly in ACK1 and ACK2, 1 elsewhere.
REQ-017 ACK1 SHALL last exactly INTA_W cycles, then GAP for exactly GAP_W cycles, then ACK2 for exactly INTA_W cycles.
REQ-018 data_in SHALL be captured into vec at the edge leaving ACK2 (last ACK2 cycle), entering HOLD with vec_valid=1.
REQ-019 Latency from intr sampled to vec_valid=1 SHALL be 2*INTA_W+GAP_W+1 edges (6 with defaults).
REQ-020 HOLD: vec, spurious and vec_valid SHALL stay stable until vec_ready=1; that edge clears vec_valid and returns to IDLE.
REQ-021 intr or if_en changing during ACK1..ACK2 SHALL NOT abort or shorten the sequence.
REQ-022 A new sequence SHALL NOT start in the HOLD->IDLE transition cycle; earliest restart is one edge after IDLE is entered.
REQ-023 vec SHALL retain its last value after consumption; only vec_valid indicates validity.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, inta_n=1, vec=8'h00, vec_valid=0, spurious=0, busy=0, counter=0, regardless of state.
REQ-025 Reset asserted mid-pulse SHALL return inta_n to 1 at that same edge; no vector is produced.

Configuration
REQ-026 Macro INTACK_SPURIOUS_EN defined: intr sampled 0 on the last ACK1 cycle SHALL set a flag, sequence completes normally, and spurious=1 accompanies vec in HOLD; cleared when next ACK1 is entered.
REQ-027 Macro INTACK_SPURIOUS_EN undefined: spurious SHALL be constant 0 and no flag register is built.

Structure
REQ-028 FSM state encoding (3-bit typedef) and the default INTA_W/GAP_W constants SHALL live in the shared interrupt package used by the priority resolver.
REQ-029 SHALL be a single module; no sub-module (counter is inline).

Verification
REQ-030 Defaults, intr=1, if_en=1, data_in=8'h4A during ACK2 -> inta_n low cycles 1-2, high 3, low 4-5; vec=8'h4A, vec_valid=1 at edge 6; vec_ready=1 at edge 6 -> IDLE at edge 7.
REQ-031 if_en=0, intr=1 for 20 cycles -> inta_n stays 1, busy stays 0; if_en->1 -> ACK1 next edge.
REQ-032 vec_ready=0 for 10 cycles in HOLD with data_in toggling -> vec stays 8'h4A, vec_valid stays 1, inta_n stays 1.
REQ-033 rst=1 during second cycle of ACK2 -> inta_n=1, vec_valid=0, busy=0 at that edge; vec=8'h00.
REQ-034 INTACK_SPURIOUS_EN defined, intr dropped to 0 before last ACK1 cycle, data_in=8'h4F -> vec=8'h4F, spurious=1; undefined -> spurious=0.
REQ-035 INTA_W=1, GAP_W=3 -> inta_n pattern 0,1,1,1,0 and vec_valid at edge 6.

Source files
------------

// File: rtl/intack_seq_pkg.sv
// Shared interrupt package: acknowledge-sequencer state encoding and
// default pulse/gap timing used by both the sequencer and the priority resolver.
package intack_seq_pkg;

  // Acknowledge sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACK1 = 3'd1,
    GAP  = 3'd2,
    ACK2 = 3'd3,
    HOLD = 3'd4
  } intack_state_e;

  // Default timing: cycles inta_n is low per pulse, cycles high between pulses.
  localparam int INTA_W_DEFAULT = 2;
  localparam int GAP_W_DEFAULT  = 1;

  // Width of the shared phase down-counter.
  localparam int CNT_W = 4;

endpackage

// File: rtl/intack_seq.sv
// intack_seq: generates the two-pulse active-low interrupt acknowledge
// sequence, captures the vector byte on the second pulse and holds it
// until the CPU core accepts it.
// Optional feature: define INTACK_SPURIOUS_EN to flag vectors whose
// request was withdrawn before the end of the first pulse.
module intack_seq
  import intack_seq_pkg::*;
#(
  parameter int INTA_W = INTA_W_DEFAULT,  // 1..15
  parameter int GAP_W  = GAP_W_DEFAULT    // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intr,
  input  logic       if_en,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic [7:0] vec,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy,
  output logic       spurious
);

  // Counter reload values: a phase lasting N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] INTA_LD = CNT_W'(INTA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_W - 1);

  intack_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inta_n_q, inta_n_d;
  logic [7:0]       vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic             busy_q, busy_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inta_n_d    = 1'b1;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    case (state_q)
      IDLE: begin
        if (intr && if_en) begin
          state_d  = ACK1;
          cnt_d    = INTA_LD;
          inta_n_d = 1'b0;
        end else begin
          cnt_d = 4'd0;
        end
      end
      ACK1: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          inta_n_d = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d  = ACK2;
          cnt_d    = INTA_LD;
          inta_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK2: begin
        if (cnt_q == 4'd0) begin
          state_d     = HOLD;
          cnt_d       = 4'd0;
          vec_d       = data_in;
          vec_valid_d = 1'b1;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          inta_n_d = 1'b0;
        end
      end
      HOLD: begin
        // Always pass through IDLE so a restart needs one more edge.
        if (vec_ready) begin
          state_d     = IDLE;
          vec_valid_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        vec_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      inta_n_q    <= 1'b1;
      vec_q       <= 8'h00;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inta_n_q    <= inta_n_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;

`ifdef INTACK_SPURIOUS_EN
  logic spur_q, spur_d;

  // Flag a request withdrawn at the last ACK1 edge; clear on the next ACK1 entry.
  always_comb begin
    spur_d = spur_q;
    if (state_q == IDLE && state_d == ACK1) begin
      spur_d = 1'b0;
    end else if (state_q == ACK1 && state_d == GAP && !intr) begin
      spur_d = 1'b1;
    end else begin
      spur_d = spur_q;
    end
  end

  // Spurious flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      spur_q <= 1'b0;
    end else begin
      spur_q <= spur_d;
    end
  end

  assign spurious = spur_q;
`else
  assign spurious = 1'b0;
`endif

endmodule

// File: tb/tb_intack_seq.sv
// Testbench for intack_seq: two instances (default timing and INTA_W=1/GAP_W=3)
// share one stimulus; a timeline model predicts every output each cycle and
// directed literal checks pin the model.
module tb_intack_seq;

  logic       clk = 1'b0;
  logic       rst, intr, if_en, vec_ready;
  logic [7:0] data_in;
  logic [1:0] inta_n_v, vec_valid_v, busy_v, spurious_v;
  logic [7:0] vec_v [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  intack_seq u_a (
    .clk(clk), .rst(rst), .intr(intr), .if_en(if_en), .data_in(data_in),
    .inta_n(inta_n_v[0]), .vec(vec_v[0]), .vec_valid(vec_valid_v[0]),
    .vec_ready(vec_ready), .busy(busy_v[0]), .spurious(spurious_v[0])
  );

  intack_seq #(.INTA_W(1), .GAP_W(3)) u_b (
    .clk(clk), .rst(rst), .intr(intr), .if_en(if_en), .data_in(data_in),
    .inta_n(inta_n_v[1]), .vec(vec_v[1]), .vec_valid(vec_valid_v[1]),
    .vec_ready(vec_ready), .busy(busy_v[1]), .spurious(spurious_v[1])
  );

  // ---------------- timeline model ----------------
  // Each instance is described by the age (edges since the start edge, start=1)
  // of its running sequence; pulses are age windows [1..W] and [W+G+1..2W+G].
  int   mw [2] = '{2, 1};
  int   mg [2] = '{1, 3};
  bit   m_act  [2];
  int   m_age  [2];
  bit   m_hold [2];
  logic [7:0] m_vec [2];
  bit   m_val  [2];
  bit   m_spur [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int a;
      a = m_age[k] + 1;
      if (rst) begin
        m_act[k] <= 1'b0; m_age[k] <= 0; m_hold[k] <= 1'b0;
        m_vec[k] <= 8'h00; m_val[k] <= 1'b0; m_spur[k] <= 1'b0;
      end else if (m_hold[k]) begin
        if (vec_ready) begin
          m_hold[k] <= 1'b0;
          m_val[k]  <= 1'b0;
        end
      end else if (m_act[k]) begin
        m_age[k] <= a;
`ifdef INTACK_SPURIOUS_EN
        if (a == mw[k] + 1 && !intr) m_spur[k] <= 1'b1;
`endif
        if (a == 2 * mw[k] + mg[k] + 1) begin
          m_act[k]  <= 1'b0;
          m_hold[k] <= 1'b1;
          m_val[k]  <= 1'b1;
          m_vec[k]  <= data_in;
        end
      end else if (intr && if_en) begin
        m_act[k]  <= 1'b1;
        m_age[k]  <= 1;
        m_spur[k] <= 1'b0;
      end
    end
  end

  function automatic bit exp_inta_n(input int k);
    bit low;
    low = m_act[k] && ((m_age[k] >= 1 && m_age[k] <= mw[k]) ||
                       (m_age[k] >= mw[k] + mg[k] + 1));
    return !low;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model.inta_n[%0d]", k), {7'd0, inta_n_v[k]}, {7'd0, exp_inta_n(k)});
      chk($sformatf("model.busy[%0d]", k), {7'd0, busy_v[k]}, {7'd0, (m_act[k] | m_hold[k])});
      chk($sformatf("model.vec_valid[%0d]", k), {7'd0, vec_valid_v[k]}, {7'd0, m_val[k]});
      chk($sformatf("model.vec[%0d]", k), vec_v[k], m_vec[k]);
      chk($sformatf("model.spurious[%0d]", k), {7'd0, spurious_v[k]}, {7'd0, m_spur[k]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    logic [7:0] exp_sp;
    logic [4:0] b_pat;
`ifdef INTACK_SPURIOUS_EN
    exp_sp = 8'd1;
`else
    exp_sp = 8'd0;
`endif
    b_pat = 5'b01110;  // instance b inta_n after edges 1..5 (bit i = edge i+1)
    rst = 1'b1; intr = 1'b0; if_en = 1'b0; vec_ready = 1'b0; data_in = 8'h00;
    tick(); tick();
    chk("reset.inta_n", {7'd0, inta_n_v[0]}, 8'd1);
    chk("reset.busy", {7'd0, busy_v[0]}, 8'd0);
    chk("reset.vec", vec_v[0], 8'h00);
    chk("reset.vec_valid", {7'd0, vec_valid_v[0]}, 8'd0);

    // Basic sequence with defaults; instance b shows the 1/3 timing.
    rst = 1'b0; intr = 1'b1; if_en = 1'b1; data_in = 8'h4A;
    for (int e = 1; e <= 7; e++) begin
      if (e == 5) vec_ready = 1'b1;
      tick();
      if (e == 3) intr = 1'b0;
      if (e <= 5) begin
        chk($sformatf("basic.a.inta_n.e%0d", e), {7'd0, inta_n_v[0]},
            {7'd0, (e == 3)});
        chk($sformatf("basic.b.inta_n.e%0d", e), {7'd0, inta_n_v[1]},
            {7'd0, b_pat[e-1]});
      end
      if (e == 5) chk("basic.a.valid.e5", {7'd0, vec_valid_v[0]}, 8'd0);
      if (e == 6) begin
        chk("basic.a.vec.e6", vec_v[0], 8'h4A);
        chk("basic.a.valid.e6", {7'd0, vec_valid_v[0]}, 8'd1);
        chk("basic.b.valid.e6", {7'd0, vec_valid_v[1]}, 8'd1);
        chk("basic.a.spurious", {7'd0, spurious_v[0]}, 8'd0);
      end
    end
    chk("basic.a.idle.e7", {7'd0, busy_v[0]}, 8'd0);
    chk("basic.a.valid.e7", {7'd0, vec_valid_v[0]}, 8'd0);
    chk("basic.a.vec_kept", vec_v[0], 8'h4A);
    vec_ready = 1'b0;

    // Interrupts disabled: no acknowledge for 20 cycles.
    intr = 1'b1; if_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("disabled.inta_n", {7'd0, inta_n_v[0]}, 8'd1);
      chk("disabled.busy", {7'd0, busy_v[0]}, 8'd0);
    end
    if_en = 1'b1;
    tick();
    chk("enable.ack1", {7'd0, inta_n_v[0]}, 8'd0);
    chk("enable.busy", {7'd0, busy_v[0]}, 8'd1);
    // Withdraw request and enable mid-sequence: sequence must still complete.
    intr = 1'b0; if_en = 1'b0; data_in = 8'h4F;
    for (int i = 0; i < 5; i++) tick();
    chk("withdrawn.vec", vec_v[0], 8'h4F);
    chk("withdrawn.valid", {7'd0, vec_valid_v[0]}, 8'd1);
    chk("withdrawn.spurious", {7'd0, spurious_v[0]}, exp_sp);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;

    // Hold stability with data_in toggling.
    intr = 1'b1; if_en = 1'b1; data_in = 8'h4A;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) intr = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      data_in = (i % 2 == 0) ? 8'hB5 : 8'h00;
      tick();
      chk("hold.vec", vec_v[0], 8'h4A);
      chk("hold.valid", {7'd0, vec_valid_v[0]}, 8'd1);
      chk("hold.inta_n", {7'd0, inta_n_v[0]}, 8'd1);
    end
    chk("hold.spurious", {7'd0, spurious_v[0]}, 8'd0);

    // No restart in the HOLD->IDLE cycle even with a pending request.
    intr = 1'b1; vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("restart.leave.busy", {7'd0, busy_v[0]}, 8'd0);
    chk("restart.leave.inta_n", {7'd0, inta_n_v[0]}, 8'd1);
    tick();
    chk("restart.ack1", {7'd0, inta_n_v[0]}, 8'd0);

    // Reset during the second ACK2 cycle (edge 6 of this sequence).
    for (int e = 2; e <= 5; e++) tick();
    chk("prereset.ack2", {7'd0, inta_n_v[0]}, 8'd0);
    rst = 1'b1; intr = 1'b0;
    tick();
    chk("midreset.inta_n", {7'd0, inta_n_v[0]}, 8'd1);
    chk("midreset.valid", {7'd0, vec_valid_v[0]}, 8'd0);
    chk("midreset.busy", {7'd0, busy_v[0]}, 8'd0);
    chk("midreset.vec", vec_v[0], 8'h00);
    rst = 1'b0;
    tick(); tick();
    chk("postreset.valid", {7'd0, vec_valid_v[0]}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
